seg_product_encoder: RTL
========================

Name: seg_product_encoder

Overview:
Sequential binary-to-seven-segment encoder for the signed-multiplier datapath. It takes a signed two's-complement product and converts its magnitude to four decimal digits using iterative shift-add-3 (double dabble), one bit per clock. It then emits the digits in the same sign + 7-segment digit format the multiplier decodes on its operand inputs, so results can drive the display or loop back as an operand.

Parameters:
W, 16, input product width in bits; legal range 8..16; iteration count equals W.
BLANK_LZ, 1, 1 = blank leading-zero digits (code 7'h00); 0 = show them as "0".

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request conversion of product_in; sampled only in IDLE
product_in  input  W  signed two's-complement product
busy  output  1  conversion in progress
done  output  1  one-cycle pulse when seg_out/ovf are updated
ovf  output  1  magnitude > 9999; registered alongside seg_out
seg_out  output  29  [6:0] units, [13:7] tens, [20:14] hundreds, [27:21] thousands, [28] sign (1 = negative)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. The ports are named clk and rst.
- Reset values: busy=0, done=0, ovf=0, seg_out=29'b0, state=IDLE, iteration counter=0, BCD shift register=0.
- Reset mid-conversion aborts the conversion. Nothing is emitted and no done pulse is produced.
- States: IDLE, CONV, EMIT.
  - IDLE→CONV on start=1.
  - CONV→EMIT after the W-th iteration.
  - EMIT→IDLE unconditionally.
- Capture edge (edge 0, start=1 in IDLE):
  - Latch sign = product_in[W-1].
  - Latch mag = |product_in|, W bits unsigned (-2^(W-1) gives 2^(W-1)).
  - Clear the 20-bit BCD register (5 digits) and the counter.
- CONV, edges 1..W:
  - Every BCD nibble ≥5 gets +3.
  - Then {bcd, mag} shifts left by 1.
  - Counter increments.
- EMIT edge (edge W+1):
  - seg_out, ovf and done=1 are registered; busy=0.
  - done is high for exactly one cycle after this edge.
  - Latency start→done = W+1 clocks (17 for W=16).
- busy is 1 from after edge 0 through the cycle before done.
- start while busy is ignored; the in-flight result is unaffected.
- start in the cycle done is high is accepted (state is IDLE).
- seg_out and ovf hold their values until the next EMIT or reset.
- Digit code mapping, value = seg[6:0] with bit0 = middle segment:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33
  - 5=5B, 6=5F, 7=70, 8=7F, 9=7B (hex)
- Leading-zero blanking (BLANK_LZ=1): thousands, hundreds and tens digits that are zero and have only zero digits above them are 7'h00. The units digit is never blanked.
- Sign bit:
  - seg_out[28] = latched sign.
  - For a zero product the sign is 0, since two's complement has no -0.
- Overflow: if the fifth BCD digit ≠0 (magnitude > 9999):
  - ovf=1.
  - All four digit fields = 7'h01 (dash); blanking is not applied.
  - seg_out[28] = sign.
- Legal multiplier results (|p| ≤ 9801) never overflow.

Test Plan:
- rst high 2 cycles then low → busy=0, done=0, ovf=0, seg_out=0. Then start, product_in=9801 → done exactly 17 clocks later; seg_out[27:0] = {7B,7F,7E,30}, [28]=0, ovf=0.
- product_in=16'hFFD6 (-42), BLANK_LZ=1 → digits {00,00,33,6D}, sign=1, ovf=0. Same input with BLANK_LZ=0 → {7E,7E,33,6D}.
- product_in=0 → {00,00,00,7E}, sign=0. product_in=10 → {00,00,30,7E}. product_in=1000 → {30,7E,7E,7E}.
- product_in=10000 → ovf=1, digits {01,01,01,01}, sign=0. product_in=16'h8000 (-32768) → ovf=1, all dashes, sign=1.
- Back-to-back operation:
  - start 9801, then pulse start=1 with product_in=5 at cycles 3 and 10 → ignored; result 9801.
  - start=1 with product_in=5 in the done cycle → second done 17 clocks later, digits {00,00,00,5B}.
- start 1234, assert rst at cycle 8 for 1 cycle → no done; busy=0 next cycle; seg_out=0. A following start of 1234 → {30,6D,79,33}.

Source files
------------

// File: rtl/seg_product_encoder.sv
// Sequential signed-product to sign + 4-digit 7-segment encoder.
// The magnitude is converted to BCD by shift-add-3 (double dabble), one bit per clock.
module seg_product_encoder #(
  parameter int W        = 16,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] product_in,
  output logic         busy,
  output logic         done,
  output logic         ovf,
  output logic [28:0]  seg_out
);

  typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [19:0]     bcd;
  logic [W-1:0]    mag;
  logic            sign;

  logic [19:0]     bcd_adj;
  logic [W+19:0]   shifted;
  logic [28:0]     seg_nxt;
  logic            ovf_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h7E;
      4'd1:    return 7'h30;
      4'd2:    return 7'h6D;
      4'd3:    return 7'h79;
      4'd4:    return 7'h33;
      4'd5:    return 7'h5B;
      4'd6:    return 7'h5F;
      4'd7:    return 7'h70;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign shifted = {bcd_adj, mag} << 1;

  // Output encoding from the final BCD value; a zero digit blanks only below blank digits.
  always_comb begin
    logic [3:0] d_th, d_hu, d_te, d_un;
    logic       blank_th, blank_hu, blank_te;
    d_th     = bcd[15:12];
    d_hu     = bcd[11:8];
    d_te     = bcd[7:4];
    d_un     = bcd[3:0];
    blank_th = BLANK_LZ && (d_th == 4'd0);
    blank_hu = blank_th && (d_hu == 4'd0);
    blank_te = blank_hu && (d_te == 4'd0);
    ovf_nxt  = |bcd[19:16];
    if (ovf_nxt) begin
      seg_nxt = {sign, {4{7'h01}}};
    end else begin
      seg_nxt = {sign,
                 blank_th ? 7'h00 : seg7(d_th),
                 blank_hu ? 7'h00 : seg7(d_hu),
                 blank_te ? 7'h00 : seg7(d_te),
                 seg7(d_un)};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bcd     <= '0;
      mag     <= '0;
      sign    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      seg_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign  <= product_in[W-1];
            mag   <= product_in[W-1] ? (~product_in + W'(1)) : product_in;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          bcd <= shifted[W+19:W];
          mag <= shifted[W-1:0];
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= EMIT;
        end
        EMIT: begin
          seg_out <= seg_nxt;
          ovf     <= ovf_nxt;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
